turn_sequencer: RTL and testbench
=================================

// Module: turn_sequencer
// PURPOSE
//  Parametrised turn controller for the 21 card game. Supports NUM_PLAYERS players.
//  Tracks which players are still in the round. Skips players who have stood or bust,
//  and flags the round as done once nobody is left.
//  Sits between the debounced KEY inputs and the hand/score datapath.
//  Its player index drives the HEX player display and selects the score register.
// PARAMETERS
//  NUM_PLAYERS     4           players per round, legal range 2..16
//  PW              $clog2(NUM_PLAYERS)  localparam, width of the player index
//  TIMEOUT_CYCLES  500000000   cycles allowed per turn (10 s at 50 MHz); used only with TURN_TIMEOUT_EN
// PORTS
//  clock       in   1            system clock; all flops use its rising edge
//  resetn      in   1            asynchronous, active-low reset
//  enable      in   1            game running; low = pause
//  next        in   1            active-high level (inverted KEY); a turn ends on press-then-release
//  stand       in   1            sampled at the press of next; 1 = current player stands
//  bust        in   1            1-cycle pulse from the score datapath: current player exceeded 21
//  new_round   in   1            1-cycle pulse: reactivate all players and restart at player 0
//  player      out  PW           index of the current player
//  player_valid out 1            1 only in TURN
//  active      out  NUM_PLAYERS  bit i = player i still in the round
//  round_done  out  1            1 only in DONE
//  turn_count  out  8            turns completed this round; saturates at 255
//  timeout     out  1            1-cycle pulse on turn expiry (tied 0 when the feature is off)
// BEHAVIOUR
//  Reset values: state=IDLE, player=0, player_valid=0, active=all ones, round_done=0,
//   turn_count=0, timeout=0. All outputs are registered.
//  States and transitions:
//  - IDLE: when enable=1, go to TURN on the next cycle; player is unchanged.
//  - TURN: on bust=1, clear active[player] and go to SEEK.
//     Otherwise on next=1, latch stand into stand_q and go to WAIT.
//  - WAIT: stay while next=1. When next=0: if stand_q, clear active[player]; then go to SEEK.
//  - SEEK: each cycle, player <= (player==NUM_PLAYERS-1) ? 0 : player+1 (wrap-around).
//     If active[new player], go to TURN. Latency is 1..NUM_PLAYERS cycles.
//     If NUM_PLAYERS steps pass with no active player, go to DONE.
//     If the only remaining active player is the current one, SEEK returns to that same
//     player after NUM_PLAYERS steps.
//  - DONE: round_done=1. Stay here until new_round.
//  Priority, highest first: resetn, enable=0, new_round, bust, timeout, next.
//  - enable=0 in any state: go to IDLE. player and active are held, so the game resumes
//    at the same player.
//  - new_round in TURN/WAIT/SEEK/DONE: active=all ones, player=0, turn_count=0, state=TURN
//    on the next cycle. new_round in IDLE is ignored.
//  - bust in WAIT/SEEK/DONE/IDLE is ignored; the datapath only pulses bust during TURN.
//  turn_count increments by 1 on every exit from TURN to WAIT or SEEK; it holds at 255.
//  stand with no press of next has no effect.
//  A next press that is already held when TURN is entered counts as a new press.
// CONFIGURATION
//  `define TURN_TIMEOUT_EN compiled in:
//   - A cycle counter clears on TURN entry and counts while in TURN.
//   - If it reaches TIMEOUT_CYCLES-1 with next=0: pulse timeout, clear active[player],
//     increment turn_count, go to SEEK.
//   - The counter is frozen while in WAIT; an expired turn is treated as a stand.
//  Not defined: no counter is built, timeout is tied to 0, and turns never expire.
// TESTING
//  1. Reset, enable=1, four press/release cycles with stand=0
//     -> player goes 0,1,2,3,0; turn_count=4; active=4'b1111.
//  2. Player 1 stands, player 2 busts; then walk the rest of the round
//     -> active=4'b1001; turn order 3,0,3,0; DONE once 0 and 3 stand; round_done=1.
//  3. Only player 2 active, press with stand=0 -> SEEK wraps back to player 2 after 4 cycles.
//  4. enable=0 while at player 2 in WAIT -> IDLE. enable=1 -> TURN at player 2, active unchanged.
//  5. new_round in DONE -> next cycle TURN, player=0, active=4'b1111, turn_count=0, round_done=0.
//     Then resetn low mid-SEEK -> outputs take their reset values asynchronously.
//  6. TURN_TIMEOUT_EN, TIMEOUT_CYCLES=16, no press -> timeout pulses 16 cycles after TURN entry;
//     active[0]=0; player advances to 1.

Source files
------------

// File: rtl/turn_sequencer_if.sv
// Signal bundle between the turn_sequencer and its surroundings (KEY front end and
// hand/score datapath). master = the driving environment, slave = the sequencer.
interface turn_sequencer_if #(
   parameter int NUM_PLAYERS = 4
);
   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

   // Handshake: player_valid qualifies player; player is meaningful only while it is 1.
   // There is no back-pressure: inputs are sampled every rising clock edge.
   logic                   enable;
   logic                   next;
   logic                   stand;
   logic                   bust;
   logic                   new_round;
   logic [PW-1:0]          player;
   logic                   player_valid;
   logic [NUM_PLAYERS-1:0] active;
   logic                   round_done;
   logic [7:0]             turn_count;
   logic                   timeout;
   logic [2:0]             state_dbg;

   modport master (
      output enable, next, stand, bust, new_round,
      input  player, player_valid, active, round_done, turn_count, timeout, state_dbg
   );

   modport slave (
      input  enable, next, stand, bust, new_round,
      output player, player_valid, active, round_done, turn_count, timeout, state_dbg
   );
endinterface

// File: rtl/turn_sequencer.sv
// Turn controller for the 21 card game: walks the active players, retires those who
// stand, bust or time out. Optional per-turn timer enabled by `define TURN_TIMEOUT_EN.
module turn_sequencer #(
   parameter int NUM_PLAYERS    = 4,
   parameter int TIMEOUT_CYCLES = 500000000
) (
   input logic             clock,
   input logic             resetn,
   turn_sequencer_if.slave bus
);
   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int SW = PW + 1;
   localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
   localparam logic [SW-1:0] LAST_STEP   = SW'(NUM_PLAYERS - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TURN = 3'd1,
      ST_WAIT = 3'd2,
      ST_SEEK = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          player_q, player_d;
   logic [PW-1:0]          player_nxt;
   logic [NUM_PLAYERS-1:0] active_q, active_d;
   logic [7:0]             turn_count_q, turn_count_d;
   logic                   stand_q, stand_d;
   logic [SW-1:0]          seek_cnt_q, seek_cnt_d;
   logic                   player_valid_q, player_valid_d;
   logic                   round_done_q, round_done_d;
   logic                   timeout_q, timeout_d;
   logic                   enter_turn;
   logic                   timeout_hit;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      state_d      = state_q;
      player_d     = player_q;
      active_d     = active_q;
      turn_count_d = turn_count_q;
      stand_d      = stand_q;
      seek_cnt_d   = seek_cnt_q;
      timeout_d    = 1'b0;
      enter_turn   = 1'b0;
      player_nxt   = (player_q == LAST_PLAYER) ? '0 : player_q + PW'(1);

      if (!bus.enable) begin
         // Pause keeps player and active so play resumes where it stopped.
         state_d = ST_IDLE;
      end else if (bus.new_round && (state_q != ST_IDLE)) begin
         active_d     = '1;
         player_d     = '0;
         turn_count_d = '0;
         state_d      = ST_TURN;
         enter_turn   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d    = ST_TURN;
               enter_turn = 1'b1;
            end
            ST_TURN: begin
               if (bus.bust || timeout_hit) begin
                  active_d[player_q] = 1'b0;
                  turn_count_d       = sat_inc(turn_count_q);
                  seek_cnt_d         = '0;
                  timeout_d          = !bus.bust;
                  state_d            = ST_SEEK;
               end else if (bus.next) begin
                  stand_d      = bus.stand;
                  turn_count_d = sat_inc(turn_count_q);
                  state_d      = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!bus.next) begin
                  if (stand_q) active_d[player_q] = 1'b0;
                  seek_cnt_d = '0;
                  state_d    = ST_SEEK;
               end
            end
            ST_SEEK: begin
               // Active is checked before the step limit so a lone survivor gets its turn back.
               player_d   = player_nxt;
               seek_cnt_d = seek_cnt_q + SW'(1);
               if (active_q[player_nxt]) begin
                  state_d    = ST_TURN;
                  enter_turn = 1'b1;
               end else if (seek_cnt_q == LAST_STEP) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end

      player_valid_d = (state_d == ST_TURN);
      round_done_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         player_q       <= '0;
         active_q       <= '1;
         turn_count_q   <= '0;
         stand_q        <= 1'b0;
         seek_cnt_q     <= '0;
         player_valid_q <= 1'b0;
         round_done_q   <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         player_q       <= player_d;
         active_q       <= active_d;
         turn_count_q   <= turn_count_d;
         stand_q        <= stand_d;
         seek_cnt_q     <= seek_cnt_d;
         player_valid_q <= player_valid_d;
         round_done_q   <= round_done_d;
         timeout_q      <= timeout_d;
      end
   end

`ifdef TURN_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmr_q, tmr_d;

   // Restarts on every TURN entry; outside TURN (notably WAIT) it simply holds.
   always_comb begin
      tmr_d = tmr_q;
      if (enter_turn) begin
         tmr_d = '0;
      end else if (state_q == ST_TURN) begin
         tmr_d = tmr_q + TW'(1);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_d;
      end
   end

   assign timeout_hit = (state_q == ST_TURN) && !bus.next && (tmr_q == TMR_LAST);
`else
   logic unused_timeout_cfg;

   // No timer is built: turns never expire and timeout stays low.
   assign timeout_hit        = 1'b0;
   assign unused_timeout_cfg = enter_turn & (TIMEOUT_CYCLES > 0);
`endif

   assign bus.player       = player_q;
   assign bus.player_valid = player_valid_q;
   assign bus.active       = active_q;
   assign bus.round_done   = round_done_q;
   assign bus.turn_count   = turn_count_q;
   assign bus.timeout      = timeout_q;
   assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer (4 players, 16-cycle turn timer when compiled in).
module tb_turn_sequencer;
   logic clock;
   logic resetn;

   turn_sequencer_if #(.NUM_PLAYERS(4)) bus ();

   turn_sequencer #(
      .NUM_PLAYERS   (4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       en, nx, st, bu, nr;
      logic [1:0] p;
      logic       pv;
      logic [3:0] act;
      logic       rd;
      logic [7:0] tc;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic v(input int en, input int nx, input int st, input int bu, input int nr,
                    input int p, input int pv, input int act, input int rd, input int tc);
      vec_t r;
      r.en = (en != 0); r.nx = (nx != 0); r.st = (st != 0); r.bu = (bu != 0); r.nr = (nr != 0);
      r.p = 2'(p); r.pv = (pv != 0); r.act = 4'(act); r.rd = (rd != 0); r.tc = 8'(tc);
      vecs.push_back(r);
   endtask

   task automatic drive(input logic en, input logic nx, input logic st, input logic bu,
                        input logic nr);
      bus.enable    = en;
      bus.next      = nx;
      bus.stand     = st;
      bus.bust      = bu;
      bus.new_round = nr;
   endtask

   task automatic step(input logic en, input logic nx, input logic st, input logic bu,
                       input logic nr);
      drive(en, nx, st, bu, nr);
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [1:0] ep, input logic epv,
                        input logic [3:0] ea, input logic erd, input logic [7:0] etc,
                        input logic eto);
      n_vec++;
      if (bus.player !== ep || bus.player_valid !== epv || bus.active !== ea ||
          bus.round_done !== erd || bus.turn_count !== etc || bus.timeout !== eto) begin
         n_bad++;
         $display("FAIL %s: got player=%0d valid=%0b active=%b done=%0b turns=%0d timeout=%0b, want player=%0d valid=%0b active=%b done=%0b turns=%0d timeout=%0b",
                  name, bus.player, bus.player_valid, bus.active, bus.round_done,
                  bus.turn_count, bus.timeout, ep, epv, ea, erd, etc, eto);
      end
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset", 2'd0, 1'b0, 4'hF, 1'b0, 8'd0, 1'b0);
      resetn = 1'b1;
   endtask

   initial begin
      // en nx st bu nr | player valid active done turns
      // Four plain turns, then a stand-without-press.
      v(1,0,0,0,0, 0,1,4'hF,0,0);
      v(1,1,0,0,0, 0,0,4'hF,0,1); v(1,0,0,0,0, 0,0,4'hF,0,1); v(1,0,0,0,0, 1,1,4'hF,0,1);
      v(1,1,0,0,0, 1,0,4'hF,0,2); v(1,0,0,0,0, 1,0,4'hF,0,2); v(1,0,0,0,0, 2,1,4'hF,0,2);
      v(1,1,0,0,0, 2,0,4'hF,0,3); v(1,0,0,0,0, 2,0,4'hF,0,3); v(1,0,0,0,0, 3,1,4'hF,0,3);
      v(1,1,0,0,0, 3,0,4'hF,0,4); v(1,0,0,0,0, 3,0,4'hF,0,4); v(1,0,0,0,0, 0,1,4'hF,0,4);
      v(1,0,1,0,0, 0,1,4'hF,0,4);
      // Player 1 stands, player 2 busts, then 3,0,3,0 until the round empties.
      v(1,1,0,0,0, 0,0,4'hF,0,5); v(1,0,0,0,0, 0,0,4'hF,0,5); v(1,0,0,0,0, 1,1,4'hF,0,5);
      v(1,1,1,0,0, 1,0,4'hF,0,6); v(1,0,0,0,0, 1,0,4'hD,0,6); v(1,0,0,0,0, 2,1,4'hD,0,6);
      v(1,0,0,1,0, 2,0,4'h9,0,7); v(1,0,0,0,0, 3,1,4'h9,0,7);
      v(1,1,0,0,0, 3,0,4'h9,0,8); v(1,0,0,0,0, 3,0,4'h9,0,8); v(1,0,0,0,0, 0,1,4'h9,0,8);
      v(1,1,0,0,0, 0,0,4'h9,0,9); v(1,0,0,0,0, 0,0,4'h9,0,9); v(1,0,0,0,0, 1,0,4'h9,0,9);
      v(1,0,0,0,0, 2,0,4'h9,0,9); v(1,0,0,0,0, 3,1,4'h9,0,9);
      v(1,1,1,0,0, 3,0,4'h9,0,10); v(1,0,0,0,0, 3,0,4'h1,0,10); v(1,0,0,0,0, 0,1,4'h1,0,10);
      v(1,1,1,0,0, 0,0,4'h1,0,11); v(1,0,0,0,0, 0,0,4'h0,0,11); v(1,0,0,0,0, 1,0,4'h0,0,11);
      v(1,0,0,0,0, 2,0,4'h0,0,11); v(1,0,0,0,0, 3,0,4'h0,0,11); v(1,0,0,0,0, 0,0,4'h0,1,11);
      v(1,0,0,0,0, 0,0,4'h0,1,11); v(1,1,0,0,0, 0,0,4'h0,1,11); v(1,0,0,0,0, 0,0,4'h0,1,11);
      // new_round out of DONE.
      v(1,0,0,0,1, 0,1,4'hF,0,0);
      // Leave only player 2 active, then a lone turn wraps back to player 2.
      v(1,1,1,0,0, 0,0,4'hF,0,1); v(1,0,0,0,0, 0,0,4'hE,0,1); v(1,0,0,0,0, 1,1,4'hE,0,1);
      v(1,1,1,0,0, 1,0,4'hE,0,2); v(1,0,0,0,0, 1,0,4'hC,0,2); v(1,0,0,0,0, 2,1,4'hC,0,2);
      v(1,1,0,0,0, 2,0,4'hC,0,3); v(1,0,0,0,0, 2,0,4'hC,0,3); v(1,0,0,0,0, 3,1,4'hC,0,3);
      v(1,1,1,0,0, 3,0,4'hC,0,4); v(1,0,0,0,0, 3,0,4'h4,0,4); v(1,0,0,0,0, 0,0,4'h4,0,4);
      v(1,0,0,0,0, 1,0,4'h4,0,4); v(1,0,0,0,0, 2,1,4'h4,0,4);
      v(1,1,0,0,0, 2,0,4'h4,0,5); v(1,0,0,0,0, 2,0,4'h4,0,5); v(1,0,0,0,0, 3,0,4'h4,0,5);
      v(1,0,0,0,0, 0,0,4'h4,0,5); v(1,0,0,0,0, 1,0,4'h4,0,5); v(1,0,0,0,0, 2,1,4'h4,0,5);
      // Pause in WAIT, resume at the same player.
      v(1,1,0,0,0, 2,0,4'h4,0,6); v(0,1,0,0,0, 2,0,4'h4,0,6); v(0,0,0,0,0, 2,0,4'h4,0,6);
      v(1,0,0,0,0, 2,1,4'h4,0,6);
      // new_round and bust ignored in IDLE; bust ignored in WAIT; held next re-counts.
      v(0,0,0,0,0, 2,0,4'h4,0,6); v(1,0,0,1,1, 2,1,4'h4,0,6);
      v(1,1,0,0,0, 2,0,4'h4,0,7); v(1,1,0,1,0, 2,0,4'h4,0,7); v(1,0,0,0,0, 2,0,4'h4,0,7);
      v(1,1,0,0,0, 3,0,4'h4,0,7); v(1,1,0,0,0, 0,0,4'h4,0,7); v(1,1,0,0,0, 1,0,4'h4,0,7);
      v(1,1,0,0,0, 2,1,4'h4,0,7); v(1,1,0,0,0, 2,0,4'h4,0,8); v(1,0,0,0,0, 2,0,4'h4,0,8);

      resetn = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      do_reset();

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].en, vecs[i].nx, vecs[i].st, vecs[i].bu, vecs[i].nr);
         check($sformatf("vec%0d", i), vecs[i].p, vecs[i].pv, vecs[i].act, vecs[i].rd,
               vecs[i].tc, 1'b0);
      end

      // Asynchronous reset while seeking: outputs drop without a clock edge.
      #2;
      resetn = 1'b0;
      #1;
      check("async_reset", 2'd0, 1'b0, 4'hF, 1'b0, 8'd0, 1'b0);
      @(posedge clock);
      #1;
      resetn = 1'b1;

      // turn_count saturation.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int t = 1; t <= 256; t++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         if (t == 255) check("turns_255", 2'd3, 1'b1, 4'hF, 1'b0, 8'd255, 1'b0);
      end
      check("turns_saturated", 2'd0, 1'b1, 4'hF, 1'b0, 8'd255, 1'b0);

      // Idle turn: expires after 16 cycles only when the timer is compiled in.
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 17; k++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef TURN_TIMEOUT_EN
         if (k < 16) check($sformatf("tmo_wait%0d", k), 2'd0, 1'b1, 4'hF, 1'b0, 8'd0, 1'b0);
         else if (k == 16) check("tmo_pulse", 2'd0, 1'b0, 4'hE, 1'b0, 8'd1, 1'b1);
         else check("tmo_next_player", 2'd1, 1'b1, 4'hE, 1'b0, 8'd1, 1'b0);
`else
         check($sformatf("no_tmo%0d", k), 2'd0, 1'b1, 4'hF, 1'b0, 8'd0, 1'b0);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
